// File: rtl/core_dispatch_scoreboard_pkg.sv
// rtl/core_dispatch_scoreboard_pkg.sv - decode types, register numbering and execution-unit classes for the dispatch scoreboard
package core_dispatch_scoreboard_pkg;

    localparam int SB_REG_W = 4;
    localparam int SB_CNT_W = 3;

    typedef logic [SB_REG_W-1:0] reg_num;

    typedef enum logic [1:0] {
        EU_ALU  = 2'd0,
        EU_MUL  = 2'd1,
        EU_LDST = 2'd2
    } eu_class;

    typedef struct packed {
        logic execute;
        logic branch;
        logic mul;
        logic ldst;
    } insn_ctrl;

    typedef struct packed {
        reg_num ra;
        reg_num rb;
        reg_num rd;
        logic   uses_ra;
        logic   uses_rb;
        logic   writeback;
    } insn_data;

    typedef struct packed {
        insn_ctrl ctrl;
        insn_data data;
    } insn_decode;

    // LDST takes precedence over MUL so a malformed decode still lands in exactly one unit class
    function automatic eu_class eu_of(insn_ctrl c);
        if (c.ldst)
            return EU_LDST;
        else if (c.mul)
            return EU_MUL;
        else
            return EU_ALU;
    endfunction

endpackage

// File: rtl/core_dispatch_scoreboard_if.sv
// rtl/core_dispatch_scoreboard_if.sv - decode-to-dispatch bundle, writeback notify and grant/busy return path
interface core_dispatch_scoreboard_if
    import core_dispatch_scoreboard_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int NUM_REGS    = 16
);
    insn_decode [ISSUE_WIDTH-1:0] cur;
    logic                         stall;
    logic                         ldst_wb;
    reg_num                       ldst_wb_rd;
    logic [ISSUE_WIDTH-1:0]       dispatch;
    logic [NUM_REGS-1:0]          busy_mask;

    modport master (
        output cur, stall, ldst_wb, ldst_wb_rd,
        input  dispatch, busy_mask
    );

    modport slave (
        input  cur, stall, ldst_wb, ldst_wb_rd,
        output dispatch, busy_mask
    );
endinterface

// File: rtl/core_dispatch_scoreboard_slot.sv
// rtl/core_dispatch_scoreboard_slot.sv - per-slot grant check, chained oldest to youngest
module core_dispatch_scoreboard_slot
    import core_dispatch_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int NUM_MUL  = 1,
    parameter int NUM_LDST = 1
) (
    input  insn_decode          insn_i,
    input  logic                chain_i,
    input  logic                stall_i,
    input  logic [NUM_REGS-1:0] raw_busy_i,
    input  logic [NUM_REGS-1:0] waw_busy_i,
    input  logic [NUM_REGS-1:0] older_rd_i,
    input  logic [2:0]          mul_cnt_i,
    input  logic [2:0]          ldst_cnt_i,
    output logic                grant_o,
    output logic                chain_o,
    output logic [NUM_REGS-1:0] older_rd_o,
    output logic [2:0]          mul_cnt_o,
    output logic [2:0]          ldst_cnt_o
);
    localparam logic [2:0] MUL_MAX  = 3'(NUM_MUL);
    localparam logic [2:0] LDST_MAX = 3'(NUM_LDST);

    eu_class             cls;
    logic [NUM_REGS-1:0] src_block;
    logic [NUM_REGS-1:0] rd_block;
    logic                src_ok;
    logic                rd_ok;
    logic                unit_ok;

    // older granted slots in this bundle count as in-flight writers for both RAW and WAW
    assign cls       = eu_of(insn_i.ctrl);
    assign src_block = raw_busy_i | older_rd_i;
    assign rd_block  = waw_busy_i | older_rd_i;
    assign src_ok    = (!insn_i.data.uses_ra || !src_block[insn_i.data.ra]) &&
                       (!insn_i.data.uses_rb || !src_block[insn_i.data.rb]);
    assign rd_ok     = !insn_i.data.writeback || !rd_block[insn_i.data.rd];
    assign unit_ok   = (cls != EU_MUL  || mul_cnt_i  < MUL_MAX) &&
                       (cls != EU_LDST || ldst_cnt_i < LDST_MAX);

    assign grant_o    = chain_i && insn_i.ctrl.execute && !stall_i && src_ok && rd_ok && unit_ok;
    assign chain_o    = grant_o && !insn_i.ctrl.branch;
    assign mul_cnt_o  = mul_cnt_i  + {2'b00, grant_o && cls == EU_MUL};
    assign ldst_cnt_o = ldst_cnt_i + {2'b00, grant_o && cls == EU_LDST};

    // fold this slot's destination into the mask seen by younger slots
    always_comb begin
        older_rd_o = older_rd_i;
        if (grant_o && insn_i.data.writeback)
            older_rd_o[insn_i.data.rd] = 1'b1;
    end

endmodule

// File: rtl/core_dispatch_scoreboard.sv
// rtl/core_dispatch_scoreboard.sv - in-order dispatch scoreboard; CORE_SCOREBOARD_BYPASS_EN enables next-cycle forwarding for RAW
module core_dispatch_scoreboard
    import core_dispatch_scoreboard_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int NUM_REGS    = 16,
    parameter int ALU_LAT     = 1,
    parameter int MUL_LAT     = 3,
    parameter int NUM_MUL     = 1,
    parameter int NUM_LDST    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    core_dispatch_scoreboard_if.slave   sb
);
    localparam logic [SB_CNT_W-1:0] ALU_CNT = SB_CNT_W'(ALU_LAT);
    localparam logic [SB_CNT_W-1:0] MUL_CNT = SB_CNT_W'(MUL_LAT);
    localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

    logic [SB_CNT_W-1:0] pend_cnt_q [NUM_REGS];
    logic [SB_CNT_W-1:0] pend_cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_ldst_q;
    logic [NUM_REGS-1:0] pend_ldst_d;
    logic [NUM_REGS-1:0] busy_mask_q;
    logic [NUM_REGS-1:0] busy_mask_d;
    logic [NUM_REGS-1:0] raw_busy;
    logic                ldst_collide;

    logic [ISSUE_WIDTH:0]   chain;
    logic [ISSUE_WIDTH-1:0] grant;
    logic [NUM_REGS-1:0]    rd_chain   [ISSUE_WIDTH+1];
    logic [2:0]             mul_chain  [ISSUE_WIDTH+1];
    logic [2:0]             ldst_chain [ISSUE_WIDTH+1];

    // reset low holds the whole bundle back through the head of the chain
    assign chain[0]      = rst_n;
    assign rd_chain[0]   = '0;
    assign mul_chain[0]  = '0;
    assign ldst_chain[0] = '0;

    // RAW view of the register state; forwarding lets a write one cycle from completion through
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
`ifdef CORE_SCOREBOARD_BYPASS_EN
            raw_busy[r] = pend_ldst_q[r] | (pend_cnt_q[r] > CNT_ONE);
`else
            raw_busy[r] = busy_mask_q[r];
`endif
        end
    end

    for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_slot
        core_dispatch_scoreboard_slot #(
            .NUM_REGS (NUM_REGS),
            .NUM_MUL  (NUM_MUL),
            .NUM_LDST (NUM_LDST)
        ) u_slot (
            .insn_i     (sb.cur[i]),
            .chain_i    (chain[i]),
            .stall_i    (sb.stall),
            .raw_busy_i (raw_busy),
            .waw_busy_i (busy_mask_q),
            .older_rd_i (rd_chain[i]),
            .mul_cnt_i  (mul_chain[i]),
            .ldst_cnt_i (ldst_chain[i]),
            .grant_o    (grant[i]),
            .chain_o    (chain[i+1]),
            .older_rd_o (rd_chain[i+1]),
            .mul_cnt_o  (mul_chain[i+1]),
            .ldst_cnt_o (ldst_chain[i+1])
        );
    end

    assign sb.dispatch  = grant;
    assign sb.busy_mask = busy_mask_q;

    // countdown and writeback clear first, then new grants overwrite their destination
    always_comb begin
        ldst_collide = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_cnt_d[r]  = (pend_cnt_q[r] != '0) ? pend_cnt_q[r] - CNT_ONE : '0;
            pend_ldst_d[r] = pend_ldst_q[r] & ~(sb.ldst_wb && sb.ldst_wb_rd == reg_num'(r));
        end
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (grant[i] && sb.cur[i].data.writeback) begin
                case (eu_of(sb.cur[i].ctrl))
                    EU_MUL:  pend_cnt_d[sb.cur[i].data.rd] = MUL_CNT;
                    EU_LDST: begin
                        pend_ldst_d[sb.cur[i].data.rd] = 1'b1;
                        if (sb.ldst_wb && sb.ldst_wb_rd == sb.cur[i].data.rd)
                            ldst_collide = 1'b1;
                    end
                    default: pend_cnt_d[sb.cur[i].data.rd] = ALU_CNT;
                endcase
            end
        end
        for (int r = 0; r < NUM_REGS; r++)
            busy_mask_d[r] = pend_ldst_d[r] | (pend_cnt_d[r] != '0);
    end

    // state registers; reset discards every pending write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                pend_cnt_q[r] <= '0;
            pend_ldst_q <= '0;
            busy_mask_q <= '0;
        end else begin
            pend_cnt_q  <= pend_cnt_d;
            pend_ldst_q <= pend_ldst_d;
            busy_mask_q <= busy_mask_d;
        end
    end

    // a writeback landing on a register that is being re-granted to LDST means WAW checking broke
    a_no_ldst_collide: assert property (@(posedge clk) disable iff (!rst_n) !ldst_collide);

endmodule

// File: tb/tb_core_dispatch_scoreboard.sv
// tb/tb_core_dispatch_scoreboard.sv - directed and randomized checks of the dispatch scoreboard against a cycle-stamp model
module tb_core_dispatch_scoreboard;
    import core_dispatch_scoreboard_pkg::*;

    localparam int IW       = 2;
    localparam int NR       = 16;
    localparam int ALU_LAT  = 1;
    localparam int MUL_LAT  = 3;
    localparam int NUM_MUL  = 1;
    localparam int NUM_LDST = 1;
`ifdef CORE_SCOREBOARD_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_dispatch_scoreboard_if #(.ISSUE_WIDTH(IW), .NUM_REGS(NR)) sb_if ();

    core_dispatch_scoreboard #(
        .ISSUE_WIDTH (IW),
        .NUM_REGS    (NR),
        .ALU_LAT     (ALU_LAT),
        .MUL_LAT     (MUL_LAT),
        .NUM_MUL     (NUM_MUL),
        .NUM_LDST    (NUM_LDST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int free_at [NR];
    bit ldst_pend [NR];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic insn_decode mk(bit ex, bit br, int cls, int rd, int ra, int rb, bit ua, bit ub, bit wb);
        insn_decode d;
        d.ctrl.execute   = ex;
        d.ctrl.branch    = br;
        d.ctrl.mul       = (cls == 1);
        d.ctrl.ldst      = (cls == 2);
        d.data.rd        = reg_num'(rd);
        d.data.ra        = reg_num'(ra);
        d.data.rb        = reg_num'(rb);
        d.data.uses_ra   = ua;
        d.data.uses_rb   = ub;
        d.data.writeback = wb;
        return d;
    endfunction

    function automatic insn_decode nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic insn_decode alu(int rd, int ra, int rb);
        return mk(1, 0, 0, rd, ra, rb, 1, 1, 1);
    endfunction
    function automatic insn_decode mul(int rd, int ra, int rb);
        return mk(1, 0, 1, rd, ra, rb, 1, 1, 1);
    endfunction
    function automatic insn_decode ldst(int rd, int ra);
        return mk(1, 0, 2, rd, ra, 0, 1, 0, 1);
    endfunction

    task automatic set2(input insn_decode s0, input insn_decode s1);
        sb_if.cur[0] = s0;
        sb_if.cur[1] = s1;
    endtask

    // a register is busy while its result stamp lies in the future or a load is outstanding
    function automatic bit m_busy(int r);
        return ldst_pend[r] || (free_at[r] > cyc);
    endfunction
    function automatic bit m_raw(int r);
        return ldst_pend[r] || ((free_at[r] - cyc) > BYP);
    endfunction

    function automatic logic [NR-1:0] m_busymask();
        logic [NR-1:0] m;
        m = '0;
        for (int r = 0; r < NR; r++) m[r] = m_busy(r);
        return m;
    endfunction

    function automatic logic [IW-1:0] m_grant();
        logic [IW-1:0] g;
        logic [NR-1:0] wr;
        int nm;
        int nl;
        insn_decode d;
        g = '0; wr = '0; nm = 0; nl = 0;
        for (int i = 0; i < IW; i++) begin
            d = sb_if.cur[i];
            if (!d.ctrl.execute || sb_if.stall) break;
            if (d.data.uses_ra && (wr[d.data.ra] || m_raw(int'(d.data.ra)))) break;
            if (d.data.uses_rb && (wr[d.data.rb] || m_raw(int'(d.data.rb)))) break;
            if (d.data.writeback && (wr[d.data.rd] || m_busy(int'(d.data.rd)))) break;
            if (d.ctrl.ldst && nl >= NUM_LDST) break;
            if (!d.ctrl.ldst && d.ctrl.mul && nm >= NUM_MUL) break;
            g[i] = 1'b1;
            if (d.data.writeback) wr[d.data.rd] = 1'b1;
            if (d.ctrl.ldst) nl++;
            else if (d.ctrl.mul) nm++;
            if (d.ctrl.branch) break;
        end
        return g;
    endfunction

    task automatic m_update(input logic [IW-1:0] g);
        insn_decode d;
        if (sb_if.ldst_wb) ldst_pend[int'(sb_if.ldst_wb_rd)] = 1'b0;
        for (int i = 0; i < IW; i++) begin
            d = sb_if.cur[i];
            if (g[i] && d.data.writeback) begin
                if (d.ctrl.ldst)     ldst_pend[int'(d.data.rd)] = 1'b1;
                else if (d.ctrl.mul) free_at[int'(d.data.rd)] = cyc + 1 + MUL_LAT;
                else                 free_at[int'(d.data.rd)] = cyc + 1 + ALU_LAT;
            end
        end
    endtask

    task automatic m_clear();
        for (int r = 0; r < NR; r++) begin
            free_at[r]   = 0;
            ldst_pend[r] = 1'b0;
        end
    endtask

    // one clock: compare mid-cycle, then advance the model on the edge
    task automatic step(input string tag, input int exp_disp);
        logic [IW-1:0] g;
        @(negedge clk);
        g = m_grant();
        check({tag, "/disp"}, 32'(sb_if.dispatch), 32'(g));
        check({tag, "/busy"}, 32'(sb_if.busy_mask), 32'(m_busymask()));
        if (exp_disp >= 0) check({tag, "/spec"}, 32'(sb_if.dispatch), 32'(exp_disp));
        @(posedge clk);
        m_update(g);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        set2(nop(), nop());
        for (int k = 0; k < n; k++) step("idle", 0);
    endtask

    initial begin
        int pend_list [$];
        int cls;
        bit ex;
        bit br;
        insn_decode d;

        m_clear();
        set2(alu(1, 2, 2), alu(3, 4, 4));
        sb_if.stall      = 1'b0;
        sb_if.ldst_wb    = 1'b0;
        sb_if.ldst_wb_rd = '0;
        @(negedge clk);
        check("rst_disp", 32'(sb_if.dispatch), 32'd0);
        check("rst_busy", 32'(sb_if.busy_mask), 32'd0);
        @(posedge clk);
        cyc++;
        #1 rst_n = 1'b1;

        // reset mid-run with pending LDST/MUL writes
        set2(ldst(10, 2), mul(11, 3, 3));
        step("t1_fill", 3);
        set2(alu(1, 2, 2), alu(3, 4, 4));
        rst_n = 1'b0;
        #1;
        check("t1_rst_disp", 32'(sb_if.dispatch), 32'd0);
        check("t1_rst_busy", 32'(sb_if.busy_mask), 32'd0);
        m_clear();
        @(posedge clk);
        cyc++;
        #1 rst_n = 1'b1;
        step("t1_pair", 3);
        idle(2);

        // intra-bundle RAW and ALU forwarding window
        set2(alu(5, 1, 1), alu(6, 5, 5));
        step("t2_raw", 1);
        set2(alu(6, 5, 5), nop());
        step("t2_c1", BYP);
        step("t2_c2", 1 - BYP);
        idle(2);

        // MUL latency seen by a dependent ALU
        set2(mul(7, 2, 2), nop());
        step("t3_mul", 1);
        set2(alu(12, 7, 7), nop());
        for (int k = 1; k <= 4; k++) begin
            check("t3_busy7", 32'(sb_if.busy_mask[7]), (k < 4) ? 32'd1 : 32'd0);
            step("t3_rd", (k == 3) ? BYP : ((k == 4) ? 1 - BYP : 0));
        end
        idle(3);

        // LDST pending until writeback
        set2(ldst(8, 3), nop());
        step("t4_ld", 1);
        set2(alu(13, 8, 8), nop());
        for (int k = 0; k < 5; k++) step("t4_wait", 0);
        sb_if.ldst_wb    = 1'b1;
        sb_if.ldst_wb_rd = reg_num'(8);
        step("t4_wb", 0);
        sb_if.ldst_wb = 1'b0;
        check("t4_busy8", 32'(sb_if.busy_mask[8]), 32'd0);
        step("t4_go", 1);
        idle(3);

        // structural limits, branch close, execute=0
        set2(mul(1, 2, 2), mul(3, 4, 4));
        step("t5_mulmul", 1);
        idle(4);
        set2(ldst(5, 2), ldst(6, 4));
        step("t5_ldld", 1);
        set2(nop(), nop());
        sb_if.ldst_wb    = 1'b1;
        sb_if.ldst_wb_rd = reg_num'(5);
        step("t5_wb", 0);
        sb_if.ldst_wb = 1'b0;
        set2(mk(1, 1, 0, 0, 1, 1, 1, 1, 0), alu(10, 11, 11));
        step("t5_br", 1);
        idle(2);
        set2(nop(), alu(14, 11, 11));
        step("t5_noex", 0);
        idle(2);

        // WAW plus stall: counters keep running
        set2(mul(9, 2, 2), nop());
        step("t6_mul", 1);
        set2(alu(9, 1, 1), nop());
        step("t6_waw", 0);
        sb_if.stall = 1'b1;
        step("t6_stall", 0);
        step("t6_stall", 0);
        sb_if.stall = 1'b0;
        check("t6_busy9", 32'(sb_if.busy_mask[9]), 32'd0);
        step("t6_go", 1);
        idle(4);

        // randomized bundles against the model
        for (int n = 0; n < 3000; n++) begin
            for (int s = 0; s < IW; s++) begin
                cls = int'($urandom_range(0, 2));
                ex  = ($urandom_range(0, 7) != 0);
                br  = (cls == 0) && ($urandom_range(0, 5) == 0);
                d = mk(ex, br, cls, int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
                       int'($urandom_range(0, NR - 1)), $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0);
                sb_if.cur[s] = d;
            end
            sb_if.stall = ($urandom_range(0, 9) == 0);
            pend_list.delete();
            for (int r = 0; r < NR; r++) if (ldst_pend[r]) pend_list.push_back(r);
            if (pend_list.size() > 0 && $urandom_range(0, 2) != 0) begin
                sb_if.ldst_wb    = 1'b1;
                sb_if.ldst_wb_rd = reg_num'(pend_list[$urandom_range(0, pend_list.size() - 1)]);
            end else begin
                sb_if.ldst_wb = 1'b0;
            end
            step("rnd", -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
